// File: rtl/sqd_pkg.sv
// Constants shared by the sync-frame transmitter and the byte-stream sequence detector.
package sqd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam int SYNC_LEN = 4;

    // Element [0] is sent first: AA, AA, FF, CF.
    localparam logic [SYNC_LEN-1:0][7:0] SYNC_PATTERN = {8'hCF, 8'hFF, 8'hAA, 8'hAA};

endpackage

// File: rtl/sync_frame_tx.sv
// Frame transmitter: emits the sync header, then forwards PAYLOAD_LEN bytes over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; outputs idle
// SYNC    | sending SYNC_PATTERN[1..SYNC_LEN-1] (element 0 is loaded on leaving IDLE)
// PAYLOAD | accepting payload bytes until PAYLOAD_LEN have been forwarded
module sync_frame_tx #(
    parameter int PAYLOAD_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       data_valid_out,
    output logic       busy_out,
    output logic       done_out,
    output logic [7:0] frame_cnt_out
);
    import sqd_pkg::*;

    localparam int PW = $clog2(PAYLOAD_LEN + 1);
    localparam int SW = $clog2(SYNC_LEN);
    localparam logic [PW-1:0] LAST_PAY  = PW'(PAYLOAD_LEN - 1);
    localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_LEN - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] sync_idx, sync_idx_nxt;
    logic [PW-1:0] pay_cnt, pay_cnt_nxt;
    logic [7:0]    frame_cnt_nxt;
    logic [7:0]    data_nxt;
    logic          valid_nxt;
    logic          done_nxt;

    assign ready_out = (state == PAYLOAD) && enable;
    assign busy_out  = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        sync_idx_nxt  = sync_idx;
        pay_cnt_nxt   = pay_cnt;
        frame_cnt_nxt = frame_cnt_out;
        data_nxt      = data_out;
        valid_nxt     = 1'b0;
        done_nxt      = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data_nxt     = SYNC_PATTERN[0];
                        valid_nxt    = 1'b1;
                        sync_idx_nxt = SW'(1);
                        state_nxt    = SYNC;
                    end
                end
                SYNC: begin
                    data_nxt  = SYNC_PATTERN[sync_idx];
                    valid_nxt = 1'b1;
                    if (sync_idx == LAST_SYNC) begin
                        sync_idx_nxt = '0;
                        pay_cnt_nxt  = '0;
                        state_nxt    = PAYLOAD;
                    end else begin
                        sync_idx_nxt = sync_idx + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (data_valid_in) begin
                        data_nxt  = data_in;
                        valid_nxt = 1'b1;
                        // Leaving for IDLE here lets a new start land right behind the last byte.
                        if (pay_cnt == LAST_PAY) begin
                            done_nxt      = 1'b1;
                            frame_cnt_nxt = frame_cnt_out + 8'd1;
                            pay_cnt_nxt   = '0;
                            state_nxt     = IDLE;
                        end else begin
                            pay_cnt_nxt = pay_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sync_idx       <= '0;
            pay_cnt        <= '0;
            frame_cnt_out  <= 8'h00;
            data_out       <= 8'h00;
            data_valid_out <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            state          <= state_nxt;
            sync_idx       <= sync_idx_nxt;
            pay_cnt        <= pay_cnt_nxt;
            frame_cnt_out  <= frame_cnt_nxt;
            data_out       <= data_nxt;
            data_valid_out <= valid_nxt;
            done_out       <= done_nxt;
        end
    end

endmodule
